// File: rtl/pio_edge_irq_multi_if.sv
// -----------------------------------------------------------------------------
// pio_edge_irq_multi_if
//
// Purpose: Avalon-MM slave bus bundle for pio_edge_irq_multi. The bus carries
// the word address, the select and write strobes, and the data in both
// directions. It also carries the level interrupt back to the master.
//
// Handshake: this slave never stalls, so there is no waitrequest.
//   - A write is accepted at the rising clk edge where chipselect=1 and
//     write_n=0. It takes effect at that same edge.
//   - readdata is registered every clock from the current address. Data for an
//     address presented before edge e is valid after edge e (latency 1),
//     whether or not chipselect is asserted.
//
// Signals:
//   address    [2:0]   word address               (master -> slave)
//   chipselect         slave select               (master -> slave)
//   write_n            active-low write strobe    (master -> slave)
//   writedata  [31:0]  write data                 (master -> slave)
//   readdata   [31:0]  registered read data       (slave  -> master)
//   irq                level interrupt, active-high (slave -> master)
// -----------------------------------------------------------------------------
interface pio_edge_irq_multi_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );
endinterface

// File: rtl/pio_edge_irq_multi.sv
// -----------------------------------------------------------------------------
// pio_edge_irq_multi
//
// Purpose: Parametrised Avalon-MM input PIO. Each of the WIDTH asynchronous
// inputs passes through the following stages:
//   1. a 2-FF synchroniser;
//   2. an optional per-bit debounce filter;
//   3. a per-bit rising/falling edge detector, with an enable for each edge;
//   4. a sticky edge-capture bit.
// Capture bits are ANDed with a per-bit mask to form one level IRQ.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   in_port    [WIDTH-1:0] asynchronous inputs
//   bus        Avalon-MM slave bundle: address, chipselect, write_n,
//              writedata, readdata and irq
//
// Register map (word address):
//   0 RO    filtered input value
//   1 RW    rise_en
//   2 RW    irq_mask
//   3 R/W1C edge_capture
//   4 RW    fall_en
//   5 RO    bit0 = irq, bit1 = |edge_capture
//   6,7     read as 0; writes ignored
//
// Latency from an in_port change to edge_capture being set is 3 edges with the
// filter bypassed, and 3+DEBOUNCE edges with the filter enabled.
// -----------------------------------------------------------------------------
module pio_edge_irq_multi #(
   parameter int               WIDTH      = 8,
   parameter int               DEBOUNCE   = 0,
   parameter int               CNT_W      = 16,
   parameter logic [WIDTH-1:0] RISE_RESET = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] FALL_RESET = {WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in_port,
   pio_edge_irq_multi_if.slave   bus
);

   // Register addresses
   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_RISE  = 3'd1;
   localparam logic [2:0] ADDR_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE  = 3'd3;
   localparam logic [2:0] ADDR_FALL  = 3'd4;
   localparam logic [2:0] ADDR_STAT  = 3'd5;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic             wr_en;
   logic [WIDTH-1:0] wdata;

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign wdata = bus.writedata[WIDTH-1:0];

   // Write data bits above WIDTH have no destination.
   if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
   end

   // ---------------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce filter
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] filt;

   if (DEBOUNCE == 0) begin : g_no_filter
      assign filt = s2;
   end else begin : g_filter
      // The counter holds the number of consecutive edges for which s2 has
      // disagreed with filt. The edge that would bring it to DEBOUNCE is the
      // edge that accepts the new level, and the count restarts there. The
      // counter therefore peaks at DEBOUNCE-1 and cannot wrap.
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

      logic [WIDTH-1:0] filt_q;
      logic [CNT_W-1:0] cnt [WIDTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
               cnt[i] <= '0;
            end
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (s2[i] == filt_q[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_LAST) begin
                  filt_q[i] <= s2[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end
         end
      end

      assign filt = filt_q;
   end

   // ---------------------------------------------------------------------------
   // Edge detection and control registers
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] w1c_clear;
   logic             irq_w;

   assign rise  = filt & ~prev & rise_en;
   assign fall  = ~filt & prev & fall_en;
   assign irq_w = |(edge_capture & irq_mask);

   // Bits cleared by a W1C write this cycle. A new edge on the same bit is
   // ORed in afterwards, so the set takes priority over the clear.
   assign w1c_clear = (wr_en && bus.address == ADDR_EDGE) ? wdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         rise_en      <= RISE_RESET;
         fall_en      <= FALL_RESET;
         irq_mask     <= '0;
         edge_capture <= '0;
      end else begin
         prev         <= filt;
         edge_capture <= (edge_capture & ~w1c_clear) | rise | fall;
         if (wr_en) begin
            case (bus.address)
               ADDR_RISE: rise_en  <= wdata;
               ADDR_MASK: irq_mask <= wdata;
               ADDR_FALL: fall_en  <= wdata;
               default:   ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read path: registered every clock from the current address
   // ---------------------------------------------------------------------------
   logic [31:0] rd_next;
   logic [31:0] readdata_q;

   always_comb begin
      rd_next = '0;
      case (bus.address)
         ADDR_DATA: rd_next = 32'(filt);
         ADDR_RISE: rd_next = 32'(rise_en);
         ADDR_MASK: rd_next = 32'(irq_mask);
         ADDR_EDGE: rd_next = 32'(edge_capture);
         ADDR_FALL: rd_next = 32'(fall_en);
         ADDR_STAT: rd_next = {30'd0, |edge_capture, irq_w};
         default:   rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= '0;
      end else begin
         readdata_q <= rd_next;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.irq      = irq_w;

endmodule

// File: tb/tb_pio_edge_irq_multi.sv
// -----------------------------------------------------------------------------
// tb_pio_edge_irq_multi
//
// Two instances share one Avalon bus stimulus:
//   dut0: DEBOUNCE=0, inputs driven by in0;
//   dut4: DEBOUNCE=4, inputs driven by in4.
// All stimulus is applied 1 time unit after a rising edge. Outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_pio_edge_irq_multi;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in4;
   int               checks   = 0;
   int               failures = 0;

   pio_edge_irq_multi_if bus0 ();
   pio_edge_irq_multi_if bus4 ();

   pio_edge_irq_multi #(.WIDTH(WIDTH), .DEBOUNCE(0)) dut0 (
      .clk     (clk),
      .reset   (reset),
      .in_port (in0),
      .bus     (bus0)
   );

   pio_edge_irq_multi #(.WIDTH(WIDTH), .DEBOUNCE(4)) dut4 (
      .clk     (clk),
      .reset   (reset),
      .in_port (in4),
      .bus     (bus4)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_idle();
      bus0.chipselect = 1'b0; bus4.chipselect = 1'b0;
      bus0.write_n    = 1'b1; bus4.write_n    = 1'b1;
      bus0.writedata  = '0;   bus4.writedata  = '0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus0.address = a;     bus4.address = a;
      bus0.chipselect = 1'b1; bus4.chipselect = 1'b1;
      bus0.write_n = 1'b0;  bus4.write_n = 1'b0;
      bus0.writedata = d;   bus4.writedata = d;
      tick(1);
      bus_idle();
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r4);
      bus0.address = a;     bus4.address = a;
      bus0.chipselect = 1'b1; bus4.chipselect = 1'b1;
      tick(1);
      r0 = bus0.readdata;
      r4 = bus4.readdata;
      bus0.chipselect = 1'b0; bus4.chipselect = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] r0, r4, exp;
      reset = 1'b1;
      in0 = '0;
      in4 = '0;
      bus_idle();
      bus0.address = 3'd0; bus4.address = 3'd0;
      tick(2);
      reset = 1'b0;
      checks++;
      if (bus0.irq !== 1'b0 || bus4.irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq got=%b/%b exp=0/0", bus0.irq, bus4.irq);
      end
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), r0, r4);
         exp = (a == 1) ? 32'h0000_00ff : 32'h0;
         checks++;
         if (r0 !== exp) begin
            failures++;
            $display("FAIL reset_read0 addr=%0d got=%h exp=%h", a, r0, exp);
         end
         checks++;
         if (r4 !== exp) begin
            failures++;
            $display("FAIL reset_read4 addr=%0d got=%h exp=%h", a, r4, exp);
         end
      end
      bus_write(3'd6, 32'hffff_ffff);
      bus_read(3'd6, r0, r4);
      checks++;
      if (r0 !== 32'h0) begin
         failures++;
         $display("FAIL addr6_write_ignored got=%h exp=%h", r0, 32'h0);
      end
   endtask

   task automatic test_rise_irq();
      logic [31:0] r0, r4;
      bus_write(3'd2, 32'h01);
      bus_write(3'd3, 32'hff);
      in0[0] = 1'b1;
      tick(2);
      checks++;
      if (bus0.irq !== 1'b0) begin
         failures++;
         $display("FAIL rise_early got=%b exp=0", bus0.irq);
      end
      tick(1);
      checks++;
      if (bus0.irq !== 1'b1) begin
         failures++;
         $display("FAIL rise_irq_k3 got=%b exp=1", bus0.irq);
      end
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h01) begin
         failures++;
         $display("FAIL rise_capture got=%h exp=%h", r0, 32'h01);
      end
      bus_read(3'd5, r0, r4);
      checks++;
      if (r0 !== 32'h03) begin
         failures++;
         $display("FAIL rise_status got=%h exp=%h", r0, 32'h03);
      end
      bus_write(3'd3, 32'h01);
      checks++;
      if (bus0.irq !== 1'b0) begin
         failures++;
         $display("FAIL w1c_irq got=%b exp=0", bus0.irq);
      end
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h0) begin
         failures++;
         $display("FAIL w1c_capture got=%h exp=%h", r0, 32'h0);
      end
   endtask

   task automatic test_fall_only();
      logic [31:0] r0, r4;
      bus_write(3'd1, 32'h00);
      bus_write(3'd4, 32'h04);
      bus_read(3'd4, r0, r4);
      checks++;
      if (r0 !== 32'h04) begin
         failures++;
         $display("FAIL fall_en_readback got=%h exp=%h", r0, 32'h04);
      end
      in0[2] = 1'b1;
      tick(6);
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h0) begin
         failures++;
         $display("FAIL fall_no_rise got=%h exp=%h", r0, 32'h0);
      end
      in0[2] = 1'b0;
      tick(6);
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h04) begin
         failures++;
         $display("FAIL fall_capture got=%h exp=%h", r0, 32'h04);
      end
      checks++;
      if (bus0.irq !== 1'b0) begin
         failures++;
         $display("FAIL fall_masked_irq got=%b exp=0", bus0.irq);
      end
      bus_write(3'd3, 32'h04);
   endtask

   task automatic test_w1c_collision();
      logic [31:0] r0, r4;
      bus_write(3'd1, 32'h02);
      bus_write(3'd4, 32'h00);
      in0[1] = 1'b1;
      tick(2);
      // The rise on bit1 is now pending. This write commits on the same edge
      // that sets the capture bit.
      bus_write(3'd3, 32'h02);
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h02) begin
         failures++;
         $display("FAIL w1c_collision got=%h exp=%h", r0, 32'h02);
      end
      bus_write(3'd3, 32'h00);
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h02) begin
         failures++;
         $display("FAIL w1c_zero_write got=%h exp=%h", r0, 32'h02);
      end
      bus_write(3'd3, 32'h02);
      bus_read(3'd3, r0, r4);
      checks++;
      if (r0 !== 32'h0) begin
         failures++;
         $display("FAIL w1c_clear_bit1 got=%h exp=%h", r0, 32'h0);
      end
   endtask

   task automatic test_debounce_glitch();
      logic [31:0] r0, r4;
      bus_write(3'd1, 32'hff);
      bus_write(3'd2, 32'h20);
      bus_write(3'd3, 32'hff);
      in4[5] = 1'b1;
      tick(3);
      in4[5] = 1'b0;
      tick(10);
      bus_read(3'd0, r0, r4);
      checks++;
      if (r4 !== 32'h0) begin
         failures++;
         $display("FAIL glitch_filt got=%h exp=%h", r4, 32'h0);
      end
      bus_read(3'd3, r0, r4);
      checks++;
      if (r4 !== 32'h0) begin
         failures++;
         $display("FAIL glitch_capture got=%h exp=%h", r4, 32'h0);
      end
      checks++;
      if (bus4.irq !== 1'b0) begin
         failures++;
         $display("FAIL glitch_irq got=%b exp=0", bus4.irq);
      end
   endtask

   task automatic test_debounce_level();
      logic [31:0] r0, r4;
      in4[5] = 1'b1;
      tick(6);
      checks++;
      if (bus4.irq !== 1'b0) begin
         failures++;
         $display("FAIL deb_early_k6 got=%b exp=0", bus4.irq);
      end
      tick(1);
      checks++;
      if (bus4.irq !== 1'b1) begin
         failures++;
         $display("FAIL deb_latency_k7 got=%b exp=1", bus4.irq);
      end
      bus_read(3'd0, r0, r4);
      checks++;
      if (r4 !== 32'h20) begin
         failures++;
         $display("FAIL deb_filt got=%h exp=%h", r4, 32'h20);
      end
      bus_read(3'd3, r0, r4);
      checks++;
      if (r4 !== 32'h20) begin
         failures++;
         $display("FAIL deb_capture got=%h exp=%h", r4, 32'h20);
      end
   endtask

   task automatic test_reset_mid_debounce();
      logic [31:0] r0, r4;
      in4 = 8'h08;
      tick(4);
      // The bit3 count has now reached 2 of 4.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++;
      if (bus4.irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_clears_irq got=%b exp=0", bus4.irq);
      end
      bus_write(3'd2, 32'h08);
      tick(5);
      checks++;
      if (bus4.irq !== 1'b0) begin
         failures++;
         $display("FAIL restart_early_r6 got=%b exp=0", bus4.irq);
      end
      tick(1);
      checks++;
      if (bus4.irq !== 1'b1) begin
         failures++;
         $display("FAIL restart_latency_r7 got=%b exp=1", bus4.irq);
      end
      bus_read(3'd3, r0, r4);
      checks++;
      if (r4 !== 32'h08) begin
         failures++;
         $display("FAIL restart_capture got=%h exp=%h", r4, 32'h08);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      in0 = '0;
      in4 = '0;
      bus_idle();
      bus0.address = 3'd0;
      bus4.address = 3'd0;
      tick(1);
      test_reset();
      test_rise_irq();
      test_fall_only();
      test_w1c_collision();
      test_debounce_glitch();
      test_debounce_level();
      test_reset_mid_debounce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pio_edge_irq_multi.md
Name: pio_edge_irq_multi

Overview:
- Parametrised Avalon-MM input PIO for Qsys peripherals such as buttons, touch or paint strobes, and sensor flags.
- Takes WIDTH asynchronous input bits through a 2-FF synchroniser and an optional per-bit debounce filter.
- Each bit has its own rising- and falling-edge enable, edge-capture bit and IRQ mask.
- Sits on the Nios II data master as a slave with one level-sensitive IRQ output.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE, 0, consecutive clocks a changed level must persist before acceptance; 0 bypasses the filter (0..65535).
- CNT_W, 16, debounce counter width; must hold DEBOUNCE-1.
- RISE_RESET, all-ones (WIDTH bits), reset value of the rise-enable register.
- FALL_RESET, 0, reset value of the fall-enable register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- in_port  in  WIDTH  asynchronous inputs
- readdata  out  32  registered read data
- irq  out  1  interrupt request, level, active-high

Behaviour:
- Reset is synchronous, active-high and sampled on the clk rising edge. It clears:
  - sync stages s1/s2, filtered value filt, previous value prev, all debounce counters;
  - irq_mask, edge_capture, readdata.
- Reset loads rise_en=RISE_RESET and fall_en=FALL_RESET.
- Reset mid-debounce discards any partial count.
- Register map (address; access; content). Reads from 6 and 7 return 0; writes to them are ignored.
  - 0 RO: filt.
  - 1 RW: rise_en.
  - 2 RW: irq_mask.
  - 3 R/W1C: edge_capture.
  - 4 RW: fall_en.
  - 5 RO: bit0 = irq, bit1 = |edge_capture.
- Write = chipselect & ~write_n; it takes effect at the same edge.
- readdata is updated every clock from the current address and zero-extended, so read latency is 1 clock regardless of chipselect.
- Synchroniser: s1<=in_port; s2<=s1.
- Filter, DEBOUNCE=0: filt = s2 (combinational).
- Filter, DEBOUNCE=N>0, per bit:
  - counter resets to 0 whenever s2==filt;
  - else it increments;
  - at the N-th consecutive clock edge with s2!=filt, filt<=s2 and counter<=0.
- Filter glitch rejection: a pulse shorter than N clocks at s2 never reaches filt. The counter must not wrap.
- Edge detect: prev<=filt every clock.
  - rise = filt & ~prev & rise_en.
  - fall = ~filt & prev & fall_en.
  - A bit with both enables set captures either edge.
- edge_capture[i] is set at the next edge when rise[i]|fall[i].
- W1C: writing 1 to address 3 clears the corresponding bits; writing 0 leaves them unchanged.
- Simultaneous W1C and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), combinational from registers. Unmasking a bit already captured raises irq on the same cycle as the mask write takes effect.
- Latency, in_port change to edge_capture set:
  - DEBOUNCE=0: 3 clock edges;
  - DEBOUNCE=N: 3+N clock edges.
- Post-reset: an input held high after reset produces a filt 0->1 transition. That is a legal rising edge and is captured if rise_en is set (default). Software clears it at init.
- Changing rise_en/fall_en affects only edges detected after the write edge. It never sets or clears existing capture bits.

Test Plan:
- Reset, then read all addresses:
  - readdata 0 for address 0, 2, 3, 5, 6, 7;
  - address 1 = RISE_RESET; address 4 = FALL_RESET;
  - irq=0.
- WIDTH=8, DEBOUNCE=0, mask=0x01, in_port bit0 0->1 at edge k:
  - edge_capture=0x01 and irq=1 after edge k+3;
  - write 0x01 to address 3 -> capture 0, irq 0.
- rise_en=0, fall_en=0x04, in_port bit2 pulses 1 then 0:
  - only the falling transition sets capture bit2 (0x04);
  - the rising transition captures nothing.
- DEBOUNCE=4:
  - a 3-clock glitch on bit5 -> filt and capture unchanged;
  - a 10-clock level change -> capture bit5 set exactly 7 edges after in_port change.
- W1C of bit1 in the same cycle a new bit1 edge is detected -> bit1 remains 1. A write of 0x00 to address 3 changes nothing.
- Assert reset while a bit3 debounce count is 2 of 4, then release with input still changed:
  - counter restarts from 0;
  - capture bit3 at edge 3+4 after release.
